burst_sequencer: RTL and testbench
==================================

BURST_SEQUENCER -- requirements
Module: burst_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all configuration counters and Addr.
REQ-002 SHALL have port Clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Arm, input, 1: in IDLE, latches configuration and enters ARMED.
REQ-005 SHALL have port Trig, input, 1: burst start request, sampled high on a rising edge.
REQ-006 SHALL have port Abort, input, 1: forces return to IDLE.
REQ-007 SHALL have port Delay_Cfg, input, CNT_W: trigger-to-first-sample delay in cycles.
REQ-008 SHALL have port Length_Cfg, input, CNT_W: samples per waveform period.
REQ-009 SHALL have port Cycles_Cfg, input, CNT_W: periods per burst; 0 = continuous.
REQ-010 SHALL have port EN, output, 1: sample-advance enable to the 34-bit burst delay stages.
REQ-011 SHALL have port Addr, output, CNT_W: sample index within the current period.
REQ-012 SHALL have port Armed, output, 1: high while in ARMED.
REQ-013 SHALL have port Busy, output, 1: high while in DELAY or RUN.
REQ-014 SHALL have port Done, output, 1: one-cycle pulse at normal burst completion.

Function
REQ-015 SHALL implement states IDLE, ARMED, DELAY, RUN and DONE; all outputs registered.
REQ-016 In IDLE with Arm=1: latch Delay_Cfg, Length_Cfg and Cycles_Cfg, then go to ARMED; later config changes are ignored until the next IDLE.
REQ-017 Latched length 0 SHALL be treated as 1.
REQ-018 In ARMED with Trig=1: go to RUN if latched delay = 0, else go to DELAY with the delay counter cleared.
REQ-019 Trig sampled high at edge k SHALL produce first EN=1 in the cycle after edge k+D, where D is the latched delay (D=0 gives EN in cycle k+1).
REQ-020 DELAY: increment the delay counter each cycle; at count D-1, go to RUN.
REQ-021 RUN:
- EN=1 every cycle.
- Addr starts at 0 and increments by 1.
- At latched length-1, Addr wraps to 0 and the period counter increments.
REQ-022 RUN with Cycles≠0: on the cycle where Addr = length-1 and period counter = Cycles-1, EN stays 1 for that last sample, then go to DONE.
REQ-023 RUN with Cycles=0: run indefinitely until Abort; the period counter SHALL wrap silently.
REQ-024 DONE: EN=0, Addr=0, Done=1 for exactly one cycle, then go to IDLE.
REQ-025 Trig SHALL be ignored outside ARMED; no retrigger during DELAY, RUN or DONE.
REQ-026 Arm SHALL be ignored outside IDLE.
REQ-027 Abort=1 in any state:
- Next state is IDLE.
- EN=0 and Addr=0 from the next cycle.
- Done is not asserted.
- Abort has priority over Arm and Trig in the same cycle.
REQ-028 Simultaneous Arm and Trig in IDLE: only the arm takes effect; Trig is ignored.
REQ-029 Armed = (state==ARMED), Busy = (state==DELAY or RUN); both registered together with the state.

Reset
REQ-030 Reset=0 SHALL asynchronously force:
- state IDLE
- EN=0, Addr=0, Armed=0, Busy=0, Done=0
- all counters and latched config to 0.
REQ-031 Reset asserted mid-burst SHALL drop EN immediately, without waiting for a clock edge.
REQ-032 After Reset deasserts, the block SHALL stay in IDLE until Arm is seen.

Verification
REQ-033 Arm with D=3, L=4, C=2, then Trig at edge k -> EN=1 for cycles k+4..k+11; Addr sequence 0,1,2,3,0,1,2,3; Done pulse in cycle k+12; back to IDLE.
REQ-034 D=0, L=1, C=1, Trig -> EN=1 for exactly one cycle (k+1) with Addr=0; Done in k+2.
REQ-035 C=0, L=5, Trig, run 23 cycles, then Abort -> Addr continuous modulo 5; EN=0 the cycle after Abort; Done never pulses.
REQ-036 Trig pulsed again during RUN, and Arm pulsed in DELAY -> no effect on burst timing or on the latched config.
REQ-037 Reset driven low asynchronously mid-RUN -> EN, Busy and Addr go to 0 before the next clock edge; no Done pulse; IDLE after release.
REQ-038 Arm and Abort in the same cycle in IDLE -> remains IDLE with Armed=0.

Source files
------------

// File: rtl/burst_sequencer_if.sv
// burst_sequencer_if -- control/config/status bundle for burst_sequencer.
//   Arm, Trig, Abort                     : control requests from the master
//   Delay_Cfg, Length_Cfg, Cycles_Cfg    : burst configuration (CNT_W each)
//   EN, Addr                             : sample-advance enable and sample index
//   Armed, Busy, Done                    : sequencer status
// master = controller/testbench side, slave = burst_sequencer side.
interface burst_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Arm;
  logic             Trig;
  logic             Abort;
  logic [CNT_W-1:0] Delay_Cfg;
  logic [CNT_W-1:0] Length_Cfg;
  logic [CNT_W-1:0] Cycles_Cfg;
  logic             EN;
  logic [CNT_W-1:0] Addr;
  logic             Armed;
  logic             Busy;
  logic             Done;

  modport master (
    output Arm, Trig, Abort, Delay_Cfg, Length_Cfg, Cycles_Cfg,
    input  EN, Addr, Armed, Busy, Done
  );

  modport slave (
    input  Arm, Trig, Abort, Delay_Cfg, Length_Cfg, Cycles_Cfg,
    output EN, Addr, Armed, Busy, Done
  );
endinterface

// File: rtl/burst_sequencer.sv
// burst_sequencer -- arms on a configuration, waits for a trigger, applies a
// programmable delay, then streams Length samples per period for Cycles periods
// (Cycles = 0 runs until aborted), driving the sample-advance enable EN and the
// in-period sample index Addr of the downstream 34-bit burst delay stages.
// Ports:
//   Clock : rising-edge clock
//   Reset : asynchronous, active-low reset
//   bus   : burst_sequencer_if.slave (Arm/Trig/Abort, *_Cfg in; EN/Addr/Armed/Busy/Done out)
// All outputs are registered; Abort has priority over everything else.
module burst_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  burst_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] delay_q, delay_nx;
  logic [CNT_W-1:0] len_q, len_nx;
  logic [CNT_W-1:0] cyc_q, cyc_nx;
  logic [CNT_W-1:0] dcnt_q, dcnt_nx;
  logic [CNT_W-1:0] pcnt_q, pcnt_nx;
  logic [CNT_W-1:0] addr_q, addr_nx;
  logic             en_q, armed_q, busy_q, done_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      delay_q <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      delay_q <= delay_nx;
      len_q   <= len_nx;
      cyc_q   <= cyc_nx;
      dcnt_q  <= dcnt_nx;
      pcnt_q  <= pcnt_nx;
      addr_q  <= addr_nx;
      // Status flags are flopped from the next state so they change together
      // with the state register.
      en_q    <= (state_nx == S_RUN);
      armed_q <= (state_nx == S_ARMED);
      busy_q  <= (state_nx == S_DELAY) || (state_nx == S_RUN);
      done_q  <= (state_nx == S_DONE);
    end
  end

  always_comb begin
    state_nx = state;
    delay_nx = delay_q;
    len_nx   = len_q;
    cyc_nx   = cyc_q;
    dcnt_nx  = dcnt_q;
    pcnt_nx  = pcnt_q;
    addr_nx  = addr_q;

    if (bus.Abort) begin
      state_nx = S_IDLE;
      dcnt_nx  = '0;
      pcnt_nx  = '0;
      addr_nx  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Arm) begin
            delay_nx = bus.Delay_Cfg;
            // A zero-length period would never wrap; run it as one sample.
            len_nx   = (bus.Length_Cfg == '0) ? ONE : bus.Length_Cfg;
            cyc_nx   = bus.Cycles_Cfg;
            state_nx = S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.Trig) begin
            dcnt_nx  = '0;
            pcnt_nx  = '0;
            addr_nx  = '0;
            state_nx = (delay_q == '0) ? S_RUN : S_DELAY;
          end
        end
        S_DELAY: begin
          // Entered only with delay_q >= 1, so delay_q - 1 cannot underflow.
          if (dcnt_q == delay_q - ONE) begin
            addr_nx  = '0;
            state_nx = S_RUN;
          end else begin
            dcnt_nx = dcnt_q + ONE;
          end
        end
        S_RUN: begin
          if (addr_q == len_q - ONE) begin
            addr_nx = '0;
            if ((cyc_q != '0) && (pcnt_q == cyc_q - ONE)) begin
              state_nx = S_DONE;
            end else begin
              // In continuous mode this wraps silently.
              pcnt_nx = pcnt_q + ONE;
            end
          end else begin
            addr_nx = addr_q + ONE;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign bus.EN    = en_q;
  assign bus.Addr  = addr_q;
  assign bus.Armed = armed_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// tb_burst_sequencer -- self-checking bench for burst_sequencer.
// Expected outputs come from a timeline model: given the number of clock edges
// since the trigger edge and the armed (D, L, C), it computes the expected
// {Armed, Busy, Done, EN, Addr} with plain arithmetic.
module tb_burst_sequencer;

  localparam int unsigned W = 16;

  logic Clock = 1'b0;
  logic Reset;

  burst_sequencer_if #(.CNT_W(W)) bus ();

  burst_sequencer #(.CNT_W(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  function automatic logic [W+3:0] pack(bit armed, bit busy, bit done, bit en,
                                        int unsigned addr);
    return {armed, busy, done, en, addr[W-1:0]};
  endfunction

  // Expected outputs observed just after trigger edge k+t.
  function automatic logic [W+3:0] model(int unsigned t, int unsigned d,
                                         int unsigned l, int unsigned c);
    int unsigned l0;
    int unsigned s;
    l0 = (l == 0) ? 1 : l;
    if (t < d) return pack(0, 1, 0, 0, 0);
    s = t - d;
    if (c != 0 && s == l0 * c) return pack(0, 0, 1, 0, 0);
    if (c != 0 && s > l0 * c) return pack(0, 0, 0, 0, 0);
    return pack(0, 1, 0, 1, s % l0);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(string tag, logic [W+3:0] exp);
    logic [W+3:0] obs;
    obs = {bus.Armed, bus.Busy, bus.Done, bus.EN, bus.Addr};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={A%b B%b D%b EN%b Addr=%0d} expected={A%b B%b D%b EN%b Addr=%0d}",
             tag, obs[W+3], obs[W+2], obs[W+1], obs[W], obs[W-1:0],
             exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic scramble_cfg();
    bus.Delay_Cfg  = W'($urandom());
    bus.Length_Cfg = W'($urandom());
    bus.Cycles_Cfg = W'($urandom());
  endtask

  // Arm with (d,l,c), trigger, follow the burst to completion (c != 0) or
  // abort after nrun observed cycles (c == 0). disturb injects an Arm with
  // fresh config during DELAY/RUN and a second Trig during RUN.
  task automatic burst(string tag, int unsigned d, int unsigned l, int unsigned c,
                       int unsigned nrun, bit disturb, bit arm_trig);
    int unsigned l0;
    int unsigned last;
    int unsigned gap;
    bus.Delay_Cfg  = W'(d);
    bus.Length_Cfg = W'(l);
    bus.Cycles_Cfg = W'(c);
    bus.Arm  = 1'b1;
    bus.Trig = arm_trig;
    tick();
    bus.Arm  = 1'b0;
    bus.Trig = 1'b0;
    check({tag, "_armed"}, pack(1, 0, 0, 0, 0));
    scramble_cfg();
    gap = $urandom_range(2, 0);
    for (int unsigned g = 0; g < gap; g++) begin
      tick();
      check({tag, "_armed_wait"}, pack(1, 0, 0, 0, 0));
    end
    bus.Trig = 1'b1;
    tick();
    bus.Trig = 1'b0;
    l0   = (l == 0) ? 1 : l;
    last = (c != 0) ? d + l0 * c + 1 : nrun - 1;
    for (int unsigned t = 0; t <= last; t++) begin
      check(tag, model(t, d, l, c));
      bus.Arm  = disturb && (t == 0);
      bus.Trig = disturb && (t == d + 1);
      if (disturb && t == 0) scramble_cfg();
      if (t < last) tick();
    end
    bus.Arm  = 1'b0;
    bus.Trig = 1'b0;
    if (c != 0) begin
      bus.Trig = 1'b1;
      tick();
      bus.Trig = 1'b0;
      check({tag, "_idle_trig_ignored"}, pack(0, 0, 0, 0, 0));
    end else begin
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      check({tag, "_abort"}, pack(0, 0, 0, 0, 0));
      tick();
      check({tag, "_after_abort"}, pack(0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    bus.Arm   = 1'b0;
    bus.Trig  = 1'b0;
    bus.Abort = 1'b0;
    bus.Delay_Cfg  = '0;
    bus.Length_Cfg = '0;
    bus.Cycles_Cfg = '0;
    Reset = 1'b0;
    #1;
    check("reset", pack(0, 0, 0, 0, 0));
    tick();
    tick();
    #2 Reset = 1'b1;
    tick();
    check("idle_after_reset", pack(0, 0, 0, 0, 0));

    // Directed scenarios.
    burst("d3_l4_c2", 3, 4, 2, 0, 1'b0, 1'b0);
    burst("d0_l1_c1", 0, 1, 1, 0, 1'b0, 1'b0);
    burst("cont_l5", 2, 5, 0, 2 + 23, 1'b0, 1'b0);
    burst("disturb", 3, 4, 2, 0, 1'b1, 1'b0);
    burst("len0", 1, 0, 3, 0, 1'b0, 1'b0);
    burst("arm_and_trig", 2, 3, 1, 0, 1'b0, 1'b1);

    // Arm and Abort together in IDLE: abort wins.
    bus.Delay_Cfg  = W'(1);
    bus.Length_Cfg = W'(2);
    bus.Cycles_Cfg = W'(1);
    bus.Arm   = 1'b1;
    bus.Abort = 1'b1;
    tick();
    bus.Arm   = 1'b0;
    bus.Abort = 1'b0;
    check("arm_abort_idle", pack(0, 0, 0, 0, 0));
    bus.Trig = 1'b1;
    tick();
    bus.Trig = 1'b0;
    check("arm_abort_trig_ignored", pack(0, 0, 0, 0, 0));

    // Abort from ARMED.
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    check("armed_before_abort", pack(1, 0, 0, 0, 0));
    bus.Abort = 1'b1;
    bus.Trig  = 1'b1;
    tick();
    bus.Abort = 1'b0;
    bus.Trig  = 1'b0;
    check("abort_over_trig", pack(0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of RUN (D=1, L=4, C=3).
    bus.Delay_Cfg  = W'(1);
    bus.Length_Cfg = W'(4);
    bus.Cycles_Cfg = W'(3);
    bus.Arm = 1'b1;
    tick();
    bus.Arm  = 1'b0;
    bus.Trig = 1'b1;
    tick();
    bus.Trig = 1'b0;
    for (int unsigned t = 1; t <= 4; t++) begin
      tick();
      check("pre_reset_run", model(t, 1, 4, 3));
    end
    #2 Reset = 1'b0;
    #1;
    check("async_reset_mid_run", pack(0, 0, 0, 0, 0));
    tick();
    check("reset_held", pack(0, 0, 0, 0, 0));
    #3 Reset = 1'b1;
    bus.Trig = 1'b1;
    tick();
    check("idle_after_release", pack(0, 0, 0, 0, 0));
    tick();
    bus.Trig = 1'b0;
    check("idle_until_arm", pack(0, 0, 0, 0, 0));

    // Randomized bursts.
    for (int i = 0; i < 20; i++) begin
      int unsigned d;
      int unsigned l;
      int unsigned c;
      d = $urandom_range(5, 0);
      l = $urandom_range(6, 0);
      c = $urandom_range(3, 0);
      burst("rand", d, l, c, d + 2 + $urandom_range(15, 0),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
